autotype_sequencer: RTL and testbench

Parametrised boot-time keystroke injector for the retro-computer board tops. After reset or on request, it steps through a table of one-hot key/reset patterns at a fixed step period. It drives the CPU reset and the board-button key inputs of the machine core (Orao, UK101 and others), so boards without buttons reach a BASIC prompt unattended. It also merges synchronised physical buttons into the same outputs and gives a user button press priority over the script.

---
 rtl/autotype_sequencer.sv | 149 ++++++++++++++
 tb/tb_autotype_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/autotype_sequencer.sv
// autotype_sequencer: boot-time keystroke and reset injector.
// Steps through a table of key patterns at a fixed step period, asserts the
// core reset during the first steps, and merges synchronised physical buttons
// into the same outputs. A fresh button press hands control to the user.
module autotype_sequencer #(
    parameter int n_keys       = 3,
    parameter int n_steps      = 16,
    parameter int step_cycles  = 8388608,
    parameter int press_cycles = 8388608,
    parameter int reset_steps  = 2,
    parameter logic [n_steps*n_keys-1:0] seq = 48'h000_0c0_010_104,
    parameter bit autostart    = 1'b1,
    parameter bit loop         = 1'b0,
    localparam int step_w      = (n_steps > 1) ? $clog2(n_steps) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic                btn_reset,
    input  logic [n_keys-1:0]   btn_keys,
    output logic                cpu_reset,
    output logic [n_keys-1:0]   keys,
    output logic                busy,
    output logic [step_w-1:0]   step
);

    localparam int cyc_w   = $clog2(step_cycles);
    localparam int btn_w   = n_keys + 1;

    // Terminal counts sized to the counters; limits compared at 32 bits so
    // that press_cycles == step_cycles == 2^k still compares correctly.
    localparam logic [cyc_w-1:0]  cyc_last  = cyc_w'(step_cycles - 1);
    localparam logic [step_w-1:0] step_last = step_w'(n_steps - 1);
    localparam logic [31:0]       press_lim = 32'(press_cycles);
    localparam logic [31:0]       reset_lim = 32'(reset_steps);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_n;
    logic [cyc_w-1:0]    cyc_q, cyc_n;
    logic [step_w-1:0]   step_q, step_n;

    logic [btn_w-1:0]    btn_meta, btn_sync, btn_prev;
    logic                btn_reset_s;
    logic [n_keys-1:0]   btn_keys_s;
    logic                takeover;
    logic                run_cur;
    logic                in_press;
    logic                in_reset_phase;

    logic [n_keys-1:0]   pattern [n_steps];

    // Unpack the flat script table into one pattern per step.
    for (genvar k = 0; k < n_steps; k++) begin : g_pattern
        assign pattern[k] = seq[k*n_keys +: n_keys];
    end

    // Two-flop synchroniser for the buttons plus a history flop for edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_meta <= '0;
            btn_sync <= '0;
            btn_prev <= '0;
        end else begin
            btn_meta <= {btn_reset, btn_keys};
            btn_sync <= btn_meta;
            btn_prev <= btn_sync;
        end
    end

    assign btn_reset_s    = btn_sync[n_keys];
    assign btn_keys_s     = btn_sync[n_keys-1:0];
    assign takeover       = |(btn_sync & ~btn_prev);
    assign run_cur        = (state_q == RUN);
    assign in_press       = (32'(cyc_q) < press_lim);
    assign in_reset_phase = (32'(step_q) < reset_lim);

    // State and counter registers; reset lands in the autostart state.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (autostart) begin
                state_q <= RUN;
            end else begin
                state_q <= IDLE;
            end
            cyc_q  <= '0;
            step_q <= '0;
        end else begin
            state_q <= state_n;
            cyc_q   <= cyc_n;
            step_q  <= step_n;
        end
    end

    // Next state: abort beats start, start beats a user takeover.
    always_comb begin
        state_n = state_q;
        cyc_n   = cyc_q;
        step_n  = step_q;
        if (abort) begin
            state_n = IDLE;
            cyc_n   = '0;
            step_n  = '0;
        end else if (start) begin
            state_n = RUN;
            cyc_n   = '0;
            step_n  = '0;
        end else if (run_cur && takeover) begin
            state_n = IDLE;
            cyc_n   = '0;
            step_n  = '0;
        end else if (run_cur) begin
            if (cyc_q == cyc_last) begin
                cyc_n = '0;
                if (step_q == step_last) begin
                    step_n = '0;
                    if (!loop) begin
                        state_n = DONE;
                    end
                end else begin
                    step_n = step_q + 1'b1;
                end
            end else begin
                cyc_n = cyc_q + 1'b1;
            end
        end
    end

    // Registered outputs derived from the current state and the buttons.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_reset <= 1'b0;
            keys      <= '0;
            busy      <= 1'b0;
            step      <= '0;
        end else begin
            cpu_reset <= (run_cur && in_reset_phase) | btn_reset_s;
            keys      <= ((run_cur && in_press) ? pattern[step_q] : '0) | btn_keys_s;
            busy      <= run_cur;
            step      <= step_q;
        end
    end

endmodule

// File: tb/tb_autotype_sequencer.sv
// Scoreboard bench for autotype_sequencer: a one-shot instance (a) and a
// looping instance (b). Stimulus queues expected outputs tagged with the
// clock count at which they must appear; a negedge monitor compares them.
module tb_autotype_sequencer;

    typedef struct {
        int         cyc;
        int         dut;
        int         tag;
        logic       cpu_reset;
        logic [1:0] keys;
        logic       busy;
        logic [1:0] step;
        logic       chk_step;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_a, reset_b;
    logic       start, abort, btn_reset;
    logic [1:0] btn_keys;

    logic       cr_a, busy_a, cr_b, busy_b;
    logic [1:0] keys_a, step_a, keys_b, step_b;

    int   cyc_cnt  = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   flush    = 1'b0;
    exp_t exp_q[$];

    // Script used by both instances: step patterns 00, 00, 10, 01.
    autotype_sequencer #(
        .n_keys(2), .n_steps(4), .step_cycles(8), .press_cycles(4),
        .reset_steps(1), .seq(8'b01_10_00_00), .autostart(1'b1), .loop(1'b0)
    ) dut_a (
        .clk(clk), .reset(reset_a), .start(start), .abort(abort),
        .btn_reset(btn_reset), .btn_keys(btn_keys),
        .cpu_reset(cr_a), .keys(keys_a), .busy(busy_a), .step(step_a)
    );

    autotype_sequencer #(
        .n_keys(2), .n_steps(4), .step_cycles(8), .press_cycles(4),
        .reset_steps(1), .seq(8'b01_10_00_00), .autostart(1'b1), .loop(1'b1)
    ) dut_b (
        .clk(clk), .reset(reset_b), .start(1'b0), .abort(1'b0),
        .btn_reset(1'b0), .btn_keys(2'b00),
        .cpu_reset(cr_b), .keys(keys_b), .busy(busy_b), .step(step_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic string tag_name(input int id);
        case (id)
            0: return "reset_state";
            1: return "boot_script";
            2: return "replay";
            3: return "start_abort";
            4: return "takeover";
            5: return "mid_reset";
            6: return "loop";
            default: return "unknown";
        endcase
    endfunction

    // Expected outputs for run time t (clocks since the first RUN cycle).
    function automatic exp_t model(input int t, input bit looping);
        exp_t e;
        int   tt;
        int   st;
        int   cy;
        tt = looping ? (t % 32) : t;
        e.cyc = 0; e.dut = 0; e.tag = 0;
        e.cpu_reset = 1'b0; e.keys = 2'b00; e.busy = 1'b0;
        e.step = 2'd0; e.chk_step = 1'b0;
        if (tt < 32) begin
            st = tt / 8;
            cy = tt % 8;
            e.cpu_reset = (st < 1);
            e.busy      = 1'b1;
            e.step      = 2'(st);
            e.chk_step  = 1'b1;
            if (st == 2 && cy < 4) e.keys = 2'b10;
            if (st == 3 && cy < 4) e.keys = 2'b01;
        end
        return e;
    endfunction

    function automatic exp_t quiet(input logic chk, input logic [1:0] k);
        exp_t e;
        e.cyc = 0; e.dut = 0; e.tag = 0;
        e.cpu_reset = 1'b0; e.keys = k; e.busy = 1'b0;
        e.step = 2'd0; e.chk_step = chk;
        return e;
    endfunction

    task automatic push_exp(input int cyc, input int dut, input int tag, input exp_t e);
        exp_t r;
        r = e;
        r.cyc = cyc;
        r.dut = dut;
        r.tag = tag;
        exp_q.push_back(r);
    endtask

    task automatic applyStimulus(input logic rst, input logic st, input logic ab,
                                 input logic [1:0] bk, input int n);
        reset_a  = rst;
        start    = st;
        abort    = ab;
        btn_keys = bk;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input exp_t e);
        logic       cr, bz;
        logic [1:0] k, s;
        bit         bad;
        if (e.dut == 0) begin
            cr = cr_a; bz = busy_a; k = keys_a; s = step_a;
        end else begin
            cr = cr_b; bz = busy_b; k = keys_b; s = step_b;
        end
        n_checks++;
        bad = (cr !== e.cpu_reset) || (k !== e.keys) || (bz !== e.busy) ||
              (e.chk_step && (s !== e.step)) || (e.cyc != cyc_cnt);
        if (bad) begin
            n_fail++;
            $display("[TB] FAIL %s dut=%0d clock=%0d due=%0d: got cpu_reset=%b keys=%b busy=%b step=%0d, want cpu_reset=%b keys=%b busy=%b step=%0d",
                     tag_name(e.tag), e.dut, cyc_cnt, e.cyc, cr, k, bz, s,
                     e.cpu_reset, e.keys, e.busy, e.step);
        end
    endtask

    // Monitor: compare every queued expectation that falls due this clock.
    always @(negedge clk) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (flush || exp_q[i].cyc <= cyc_cnt) begin
                checkOutput(exp_q[i]);
                exp_q.delete(i);
            end
        end
    end

    initial begin
        int   base;
        int   k;
        exp_t e;

        reset_a   = 1'b1;
        reset_b   = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        btn_reset = 1'b0;
        btn_keys  = 2'b00;

        // Reset state of both instances.
        for (int c = 2; c <= 3; c++) begin
            push_exp(c, 0, 0, quiet(1'b1, 2'b00));
            push_exp(c, 1, 0, quiet(1'b1, 2'b00));
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 3);

        // Boot script after reset release, ending in DONE.
        base = cyc_cnt;
        for (int t = 0; t <= 32; t++) push_exp(base + 1 + t, 0, 1, model(t, 1'b0));
        push_exp(base + 34, 1, 0, quiet(1'b1, 2'b00));
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 34);

        // Start pulse from DONE replays the whole script.
        base = cyc_cnt;
        push_exp(base + 1, 0, 2, quiet(1'b0, 2'b00));
        for (int t = 0; t <= 32; t++) push_exp(base + 2 + t, 0, 2, model(t, 1'b0));
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 34);

        // Start and abort together in step 2 cycle 1: abort wins, no restart.
        base = cyc_cnt;
        for (int t = 0; t <= 17; t++) push_exp(base + 2 + t, 0, 3, model(t, 1'b0));
        for (int o = 20; o <= 25; o++) push_exp(base + o, 0, 3, quiet(1'b1, 2'b00));
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 17);
        applyStimulus(1'b0, 1'b1, 1'b1, 2'b00, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 7);

        // User key press during step 2 takes over for 20 clocks.
        base = cyc_cnt;
        k    = base + 20;
        for (int t = 0; t <= 20; t++) push_exp(base + 2 + t, 0, 4, model(t, 1'b0));
        e = model(21, 1'b0);
        e.keys = 2'b01;
        push_exp(k + 3, 0, 4, e);
        for (int o = 4; o <= 22; o++) push_exp(k + o, 0, 4, quiet(1'b0, 2'b01));
        push_exp(k + 23, 0, 4, quiet(1'b0, 2'b00));
        push_exp(k + 24, 0, 4, quiet(1'b0, 2'b00));
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 19);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b01, 20);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 5);

        // One-clock reset in mid step 2 restarts the script from step 0.
        base = cyc_cnt;
        k    = base + 22;
        for (int t = 0; t <= 20; t++) push_exp(base + 2 + t, 0, 5, model(t, 1'b0));
        push_exp(k + 1, 0, 5, quiet(1'b1, 2'b00));
        for (int t = 0; t <= 9; t++) push_exp(k + 2 + t, 0, 5, model(t, 1'b0));
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 21);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 11);

        // Looping instance: 70 clocks, wrapping at 32 and 64.
        base = cyc_cnt;
        for (int t = 0; t <= 69; t++) push_exp(base + 1 + t, 1, 6, model(t, 1'b1));
        reset_b = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 71);

        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 2);
        flush = 1'b1;
        @(negedge clk);
        #1;
        $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
